// File: rtl/vga_sync_gen_pkg.sv
// Shared VGA timing defaults and coordinate type for the sync generator, paint stage and
// frame-buffer address logic.
package vga_sync_gen_pkg;

    localparam int COORD_W = 10;
    localparam int MAX_TOTAL = 1 << COORD_W;

    typedef logic [COORD_W-1:0] coord_t;

    // 640x480@60 defaults
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_CLK_DIV  = 2;

    function automatic int timing_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// Divides clk down to the pixel rate; advance is high on the last clk of each pixel period.
module pixel_tick_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    output logic advance
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_reg;

    assign advance = (div_cnt_reg == DIV_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_reg <= '0;
        end else if (advance) begin
            div_cnt_reg <= '0;
        end else begin
            div_cnt_reg <= div_cnt_reg + DIV_W'(1);
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing: beam counters plus registered sync/blanking/strobe outputs, all derived
// from the next counter values so they line up with cur_x/cur_y in the same cycle.
module vga_sync_gen
    import vga_sync_gen_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               pix_tick,
    output logic [COORD_W-1:0] cur_x,
    output logic [COORD_W-1:0] cur_y,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic               line_start,
    output logic               frame_start
);

    localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam coord_t H_LAST       = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST       = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS        = coord_t'(H_ACTIVE);
    localparam coord_t V_VIS        = coord_t'(V_ACTIVE);
    localparam coord_t H_SYNC_START = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t H_SYNC_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam coord_t V_SYNC_START = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t V_SYNC_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

    generate
        if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
            $error("vga_sync_gen: H_TOTAL/V_TOTAL exceed coordinate range");
        end
        if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
            $error("vga_sync_gen: CLK_DIV must be in 1..16");
        end
    endgenerate

    logic   advance;
    coord_t x_next, y_next;
    logic   hsync_next, vsync_next, video_next;

    coord_t cur_x_reg, cur_y_reg;
    logic   pix_tick_reg, hsync_reg, vsync_reg, video_on_reg, line_start_reg, frame_start_reg;

    pixel_tick_div #(
        .CLK_DIV(CLK_DIV)
    ) u_div (
        .clk    (clk),
        .reset  (reset),
        .advance(advance)
    );

    always_comb begin
        x_next = cur_x_reg + coord_t'(1);
        y_next = cur_y_reg;
        if (cur_x_reg == H_LAST) begin
            x_next = '0;
            y_next = (cur_y_reg == V_LAST) ? '0 : cur_y_reg + coord_t'(1);
        end
    end

    // Decode from the next position so the registered flags match the registered counters
    always_comb begin
        hsync_next = ~SYNC_POL;
        vsync_next = ~SYNC_POL;
        if (x_next >= H_SYNC_START && x_next <= H_SYNC_END) begin
            hsync_next = SYNC_POL;
        end
        if (y_next >= V_SYNC_START && y_next <= V_SYNC_END) begin
            vsync_next = SYNC_POL;
        end
        video_next = (x_next < H_VIS) && (y_next < V_VIS);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_x_reg       <= H_LAST;
            cur_y_reg       <= V_LAST;
            pix_tick_reg    <= 1'b0;
            hsync_reg       <= ~SYNC_POL;
            vsync_reg       <= ~SYNC_POL;
            video_on_reg    <= 1'b0;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
        end else if (advance) begin
            cur_x_reg       <= x_next;
            cur_y_reg       <= y_next;
            pix_tick_reg    <= 1'b1;
            hsync_reg       <= hsync_next;
            vsync_reg       <= vsync_next;
            video_on_reg    <= video_next;
            line_start_reg  <= (x_next == '0);
            frame_start_reg <= (x_next == '0) && (y_next == '0);
        end else begin
            pix_tick_reg    <= 1'b0;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
        end
    end

    assign pix_tick    = pix_tick_reg;
    assign cur_x       = cur_x_reg;
    assign cur_y       = cur_y_reg;
    assign hsync       = hsync_reg;
    assign vsync       = vsync_reg;
    assign video_on    = video_on_reg;
    assign line_start  = line_start_reg;
    assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default-timing instance walked through a line by a vector table,
// plus two reduced-timing instances (CLK_DIV=1, and CLK_DIV=4 with positive sync) run over full frames.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_d = 1'b1, rst_s = 1'b1, rst_p = 1'b1;

    logic       d_tick, d_hs, d_vs, d_von, d_ls, d_fs;
    logic [9:0] d_x, d_y;
    logic       s_tick, s_hs, s_vs, s_von, s_ls, s_fs;
    logic [9:0] s_x, s_y;
    logic       p_tick, p_hs, p_vs, p_von, p_ls, p_fs;
    logic [9:0] p_x, p_y;

    vga_sync_gen u_d (
        .clk(clk), .reset(rst_d), .pix_tick(d_tick), .cur_x(d_x), .cur_y(d_y),
        .hsync(d_hs), .vsync(d_vs), .video_on(d_von), .line_start(d_ls), .frame_start(d_fs)
    );

    // Small raster: H 8/2/3/2 (total 15, hsync 10..12), V 6/2/2/3 (total 13, vsync 8..9)
    vga_sync_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .CLK_DIV(1), .SYNC_POL(1'b0)
    ) u_s (
        .clk(clk), .reset(rst_s), .pix_tick(s_tick), .cur_x(s_x), .cur_y(s_y),
        .hsync(s_hs), .vsync(s_vs), .video_on(s_von), .line_start(s_ls), .frame_start(s_fs)
    );

    vga_sync_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .CLK_DIV(4), .SYNC_POL(1'b1)
    ) u_p (
        .clk(clk), .reset(rst_p), .pix_tick(p_tick), .cur_x(p_x), .cur_y(p_y),
        .hsync(p_hs), .vsync(p_vs), .video_on(p_von), .line_start(p_ls), .frame_start(p_fs)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic chk_d_outputs(input string tag, input int x, input int y, input int tick,
                                 input int hs, input int vs, input int von, input int ls, input int fs);
        chk({tag, ".cur_x"}, int'(d_x), x);
        chk({tag, ".cur_y"}, int'(d_y), y);
        chk({tag, ".pix_tick"}, int'(d_tick), tick);
        chk({tag, ".hsync"}, int'(d_hs), hs);
        chk({tag, ".vsync"}, int'(d_vs), vs);
        chk({tag, ".video_on"}, int'(d_von), von);
        chk({tag, ".line_start"}, int'(d_ls), ls);
        chk({tag, ".frame_start"}, int'(d_fs), fs);
    endtask

    // Advance the default DUT by n pixel ticks, each bounded to a few clocks
    task automatic step_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            int c;
            c = 0;
            do begin
                @(posedge clk);
                #1;
                c++;
            end while (!d_tick && c < 16);
            if (!d_tick) begin
                chk("tick_timeout", 0, 1);
                return;
            end
        end
    endtask

    typedef struct {
        int ticks;
        int x;
        int y;
        int hs;
        int von;
        int ls;
    } vec_t;

    vec_t tbl[10];

    // Full-frame run of a reduced-timing instance against a plain raster model
    task automatic run_small(input int inst, input int div, input int pol, input int ncyc);
        int mx, my, e, last_fs, tick_e;
        int ex_hs, ex_vs, ex_von, ex_ls, ex_fs;
        logic       a_tick, a_hs, a_vs, a_von, a_ls, a_fs;
        logic [9:0] a_x, a_y;
        bit ok;
        string nm;
        nm = (inst == 0) ? "div1" : "div4_pos";
        if (inst == 0) rst_s = 1'b1; else rst_p = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        if (inst == 0) {a_tick, a_x, a_y, a_hs, a_vs, a_von, a_ls, a_fs} = {s_tick, s_x, s_y, s_hs, s_vs, s_von, s_ls, s_fs};
        else           {a_tick, a_x, a_y, a_hs, a_vs, a_von, a_ls, a_fs} = {p_tick, p_x, p_y, p_hs, p_vs, p_von, p_ls, p_fs};
        chk({nm, "_rst.cur_x"}, int'(a_x), 14);
        chk({nm, "_rst.cur_y"}, int'(a_y), 12);
        chk({nm, "_rst.hsync"}, int'(a_hs), 1 - pol);
        chk({nm, "_rst.vsync"}, int'(a_vs), 1 - pol);
        chk({nm, "_rst.video_on"}, int'(a_von), 0);
        chk({nm, "_rst.pix_tick"}, int'(a_tick), 0);
        $display("%s: reset state x=%0d y=%0d hs=%b vs=%b", nm, a_x, a_y, a_hs, a_vs);
        if (inst == 0) rst_s = 1'b0; else rst_p = 1'b0;
        mx = 14; my = 12; e = 0; last_fs = -1;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk);
            #1;
            e++;
            tick_e = (e % div == 0) ? 1 : 0;
            if (tick_e == 1) begin
                if (mx == 14) begin
                    mx = 0;
                    my = (my == 12) ? 0 : my + 1;
                end else begin
                    mx = mx + 1;
                end
            end
            ex_hs  = (mx >= 10 && mx <= 12) ? pol : 1 - pol;
            ex_vs  = (my >= 8 && my <= 9) ? pol : 1 - pol;
            ex_von = (mx < 8 && my < 6) ? 1 : 0;
            ex_ls  = (tick_e == 1 && mx == 0) ? 1 : 0;
            ex_fs  = (tick_e == 1 && mx == 0 && my == 0) ? 1 : 0;
            if (inst == 0) {a_tick, a_x, a_y, a_hs, a_vs, a_von, a_ls, a_fs} = {s_tick, s_x, s_y, s_hs, s_vs, s_von, s_ls, s_fs};
            else           {a_tick, a_x, a_y, a_hs, a_vs, a_von, a_ls, a_fs} = {p_tick, p_x, p_y, p_hs, p_vs, p_von, p_ls, p_fs};
            ok = (int'(a_x) == mx) && (int'(a_y) == my) && (int'(a_tick) == tick_e) &&
                 (int'(a_hs) == ex_hs) && (int'(a_vs) == ex_vs) && (int'(a_von) == ex_von) &&
                 (int'(a_ls) == ex_ls) && (int'(a_fs) == ex_fs);
            n_checks++;
            if (ok) n_pass++;
            else $display("FAIL %s_cycle %0d: got x=%0d y=%0d tick=%b hs=%b vs=%b von=%b ls=%b fs=%b, expected x=%0d y=%0d tick=%0d hs=%0d vs=%0d von=%0d ls=%0d fs=%0d",
                          nm, c, a_x, a_y, a_tick, a_hs, a_vs, a_von, a_ls, a_fs,
                          mx, my, tick_e, ex_hs, ex_vs, ex_von, ex_ls, ex_fs);
            if (a_fs) begin
                if (last_fs >= 0) chk({nm, "_frame_period"}, c - last_fs, 195 * div);
                last_fs = c;
            end
        end
        chk({nm, "_frame_seen"}, (last_fs >= 0) ? 1 : 0, 1);
        $display("%s: %0d cycles checked, last frame_start at cycle %0d", nm, ncyc, last_fs);
        if (inst == 0) rst_s = 1'b1; else rst_p = 1'b1;
    endtask

    initial begin
        //            ticks   x    y  hs von ls
        tbl[0] = '{    1,    1,   0, 1, 1, 0};
        tbl[1] = '{  638,  639,   0, 1, 1, 0};
        tbl[2] = '{    1,  640,   0, 1, 0, 0};
        tbl[3] = '{   15,  655,   0, 1, 0, 0};
        tbl[4] = '{    1,  656,   0, 0, 0, 0};
        tbl[5] = '{   95,  751,   0, 0, 0, 0};
        tbl[6] = '{    1,  752,   0, 1, 0, 0};
        tbl[7] = '{   47,  799,   0, 1, 0, 0};
        tbl[8] = '{    1,    0,   1, 1, 1, 1};
        tbl[9] = '{  799,  799,   1, 1, 0, 0};

        // Reset for 3 clk, then first pixel lands on the 2nd edge after release
        repeat (3) @(posedge clk);
        #1;
        chk_d_outputs("d_reset", 799, 524, 0, 1, 1, 0, 0, 0);
        rst_d = 1'b0;
        @(posedge clk);
        #1;
        chk_d_outputs("d_release1", 799, 524, 0, 1, 1, 0, 0, 0);
        @(posedge clk);
        #1;
        chk_d_outputs("d_first_pix", 0, 0, 1, 1, 1, 1, 1, 1);
        $display("default: first pixel x=%0d y=%0d fs=%b", d_x, d_y, d_fs);

        for (int i = 0; i < 10; i++) begin
            step_ticks(tbl[i].ticks);
            chk_d_outputs($sformatf("d_vec%0d", i), tbl[i].x, tbl[i].y, 1, tbl[i].hs, 1,
                          tbl[i].von, tbl[i].ls, 0);
            @(posedge clk);
            #1;
            chk_d_outputs($sformatf("d_vec%0d_hold", i), tbl[i].x, tbl[i].y, 0, tbl[i].hs, 1,
                          tbl[i].von, 0, 0);
            $display("default vec %0d: x=%0d y=%0d hs=%b von=%b", i, d_x, d_y, d_hs, d_von);
        end

        // Mid-frame reset for one clk, then re-lock to (0,0) two clocks after release
        step_ticks(301);
        chk_d_outputs("d_pre_reset", 300, 2, 1, 1, 1, 1, 0, 0);
        rst_d = 1'b1;
        @(posedge clk);
        #1;
        chk_d_outputs("d_mid_reset", 799, 524, 0, 1, 1, 0, 0, 0);
        rst_d = 1'b0;
        @(posedge clk);
        #1;
        chk_d_outputs("d_relock1", 799, 524, 0, 1, 1, 0, 0, 0);
        @(posedge clk);
        #1;
        chk_d_outputs("d_relock2", 0, 0, 1, 1, 1, 1, 1, 1);
        $display("default: mid-frame reset re-locked at x=%0d y=%0d", d_x, d_y);

        run_small(0, 1, 0, 420);
        run_small(1, 4, 1, 1600);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
